// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC read path: PicoBlaze port IDs,
// FSM state encodings, status bit positions and a BCD helper.
package rtc_bus_pkg;

  localparam logic [7:0] PORT_ADDR   = 8'h10;
  localparam logic [7:0] PORT_DATA   = 8'h11;
  localparam logic [7:0] PORT_STATUS = 8'h12;

  localparam int BUSY_B  = 0;
  localparam int VALID_B = 1;
  localparam int OVR_B   = 2;
  localparam int BCD_B   = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HOLD,
    TURN,
    READ,
    RECOVER
  } state_e;

  function automatic logic bcd_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// 8-bit loadable down-counter shared by every timed bus phase.
// Ports: clock, reset (async low), load_i, load_val_i, zero_o.
module rtc_phase_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/rtc_bus_reader.sv
// One RTC register read per PicoBlaze PORT_ADDR write over the
// muxed A/D bus; captured byte and status returned on in_port.
// Ports: clock/reset, PicoBlaze (in_dato, port_id, write_strobe,
// read_strobe, in_port), RTC pads (ad_out, ad_oe, ad_in, ale,
// cs_n, rd_n, wr_n), busy.
// Optional: define RTC_BCD_CHECK_EN for the sticky BCD error bit.
module rtc_bus_reader
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = 10,
  parameter int T_TURN  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_dato,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       ale,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       busy
);

  // Counter runs load..0, so a phase of N cycles loads N-1.
  localparam logic [7:0] PH_LD = 8'(T_PHASE - 1);
  localparam logic [7:0] TU_LD = 8'(T_TURN - 1);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ovr_q, ovr_d;
  logic [7:0] in_port_q, in_port_d;

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_zero;
  logic       capture;
  logic       bcd_err;

  logic wr_addr, rd_data, rd_stat, start;

  assign wr_addr = write_strobe && (port_id == PORT_ADDR);
  assign rd_data = read_strobe && (port_id == PORT_DATA);
  assign rd_stat = read_strobe && (port_id == PORT_STATUS);
  assign start   = wr_addr && (state_q == IDLE);

  rtc_phase_timer u_tmr (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = PH_LD;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ADDR;
          tmr_load = 1'b1;
        end
      end
      ADDR: begin
        if (tmr_zero) state_d = HOLD;
      end
      HOLD: begin
        state_d  = TURN;
        tmr_load = 1'b1;
        tmr_val  = TU_LD;
      end
      TURN: begin
        if (tmr_zero) begin
          state_d  = READ;
          tmr_load = 1'b1;
        end
      end
      READ: begin
        if (tmr_zero) begin
          state_d  = RECOVER;
          tmr_load = 1'b1;
          capture  = 1'b1;
        end
      end
      RECOVER: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad controls decode straight from state so reset releases
  // the bus without waiting for a clock edge.
  assign busy   = (state_q != IDLE);
  assign ale    = (state_q == ADDR);
  assign ad_oe  = (state_q == ADDR) || (state_q == HOLD);
  assign ad_out = ad_oe ? addr_q : 8'h00;
  assign rd_n   = (state_q != READ);
  assign cs_n   = !((state_q == ADDR) || (state_q == HOLD) ||
                    (state_q == TURN) || (state_q == READ));
  assign wr_n   = 1'b1;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (start)   addr_d = in_dato;
    if (capture) data_d = ad_in;
    // Set beats clear when both land on the same edge.
    if (capture)      valid_d = 1'b1;
    else if (rd_data) valid_d = 1'b0;
    if (wr_addr && busy) ovr_d = 1'b1;
    else if (rd_stat)    ovr_d = 1'b0;
  end

`ifdef RTC_BCD_CHECK_EN
  logic bcd_q, bcd_d;

  always_comb begin
    bcd_d = bcd_q;
    if (capture && bcd_bad(ad_in)) bcd_d = 1'b1;
    else if (rd_stat)              bcd_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) bcd_q <= 1'b0;
    else        bcd_q <= bcd_d;
  end

  assign bcd_err = bcd_q;
`else
  assign bcd_err = 1'b0;
`endif

  always_comb begin
    in_port_d = 8'h00;
    unique case (1'b1)
      (port_id == PORT_DATA): in_port_d = data_q;
      (port_id == PORT_STATUS): begin
        in_port_d[BUSY_B]  = busy;
        in_port_d[VALID_B] = valid_q;
        in_port_d[OVR_B]   = ovr_q;
        in_port_d[BCD_B]   = bcd_err;
      end
      default: in_port_d = 8'h00;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      in_port_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      in_port_q <= in_port_d;
    end
  end

  assign in_port = in_port_q;

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Scoreboard bench for rtc_bus_reader: reads queue expected
// bytes, a negedge monitor pops them as in_port updates.
module tb_rtc_bus_reader;
  import rtc_bus_pkg::*;

  logic       clock;
  logic       reset;
  logic [7:0] in_dato;
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       ale;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       busy;

  rtc_bus_reader dut (
    .clock        (clock),
    .reset        (reset),
    .in_dato      (in_dato),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .ad_out       (ad_out),
    .ad_oe        (ad_oe),
    .ad_in        (ad_in),
    .ale          (ale),
    .cs_n         (cs_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .busy         (busy)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rd_pend = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cyc++;
    rd_pend <= read_strobe;
  end

  // Monitor: in_port is registered, valid the cycle after a strobe.
  always @(negedge clock) begin
    if (rd_pend) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: got %h want none", in_port);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (in_port !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, in_port, e.val);
        end
      end
    end
  end

  // Contention monitor on the shared A/D pads.
  logic prev_oe  = 1'b0;
  logic prev_rdn = 1'b1;
  int   oe_fall  = 0;
  always @(negedge clock) begin
    if (ad_oe && !rd_n) begin
      total++;
      bad++;
      $display("FAIL contention: ad_oe=%b rd_n=%b want not both", ad_oe, rd_n);
    end
    if (prev_oe && !ad_oe) oe_fall = cyc;
    if (prev_rdn && !rd_n) begin
      total++;
      if (cyc - oe_fall < 2) begin
        bad++;
        $display("FAIL turn_gap: got %0d want >=2", cyc - oe_fall);
      end
    end
    prev_oe  = ad_oe;
    prev_rdn = rd_n;
  end

  task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(logic [7:0] p, logic [7:0] d);
    port_id      = p;
    in_dato      = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id      = 8'h00;
  endtask

  task automatic do_read(logic [7:0] p, logic [7:0] exp, string nm);
    exp_t e;
    e.name = nm;
    e.val  = exp;
    sb.push_back(e);
    port_id     = p;
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk1(nm, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ale, n_rd, n_busy, bad_ad;
    logic done;

    reset        = 1'b0;
    in_dato      = 8'h00;
    port_id      = 8'h00;
    write_strobe = 1'b0;
    read_strobe  = 1'b0;
    ad_in        = 8'h00;

    #12;
    chk8("rst_in_port", in_port, 8'h00);
    chk8("rst_ad_out", ad_out, 8'h00);
    chk1("rst_ad_oe", ad_oe, 1'b0);
    chk1("rst_ale", ale, 1'b0);
    chk1("rst_cs_n", cs_n, 1'b1);
    chk1("rst_rd_n", rd_n, 1'b1);
    chk1("rst_wr_n", wr_n, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    @(negedge clock) reset = 1'b1;
    tick();
    do_read(PORT_STATUS, 8'h00, "rst_status");
    do_read(PORT_DATA, 8'h00, "rst_data");

    // Basic read of register 0x21.
    ad_in = 8'h45;
    do_write(PORT_ADDR, 8'h21);
    n_ale  = 0;
    n_rd   = 0;
    n_busy = 0;
    bad_ad = 0;
    done   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      n_busy++;
      if (ale) begin
        n_ale++;
        if (ad_out !== 8'h21) bad_ad++;
      end
      if (!rd_n) n_rd++;
    end
    chk1("t1_done", done, 1'b1);
    chk8("t1_ale_cycles", 8'(n_ale), 8'd10);
    chk8("t1_rd_cycles", 8'(n_rd), 8'd10);
    chk8("t1_ad_out_bad", 8'(bad_ad), 8'd0);
    chk8("t1_strobe_to_idle", 8'(n_busy + 1), 8'd34);
    tick();
    do_read(PORT_STATUS, 8'h02, "t1_status");
    do_read(PORT_DATA, 8'h45, "t1_data");

    // Overrun: second address write mid-transaction.
    ad_in = 8'h37;
    do_write(PORT_ADDR, 8'h21);
    repeat (4) tick();
    do_write(PORT_ADDR, 8'h22);
    @(negedge clock);
    chk1("t2_ale", ale, 1'b1);
    chk8("t2_ad_out", ad_out, 8'h21);
    tick();
    do_read(PORT_STATUS, 8'h05, "t2_status_busy");
    wait_idle("t2_idle");
    do_read(PORT_DATA, 8'h37, "t2_data");
    do_read(PORT_STATUS, 8'h00, "t2_status_idle");

    // Data read on the exact edge data_valid is set.
    ad_in = 8'h12;
    do_write(PORT_ADDR, 8'h30);
    repeat (22) tick();
    do_read(PORT_DATA, 8'h37, "t3_race_data");
    wait_idle("t3_idle");
    do_read(PORT_STATUS, 8'h02, "t3_status");
    do_read(PORT_DATA, 8'h12, "t3_data");

    // Asynchronous reset during READ.
    ad_in = 8'h55;
    do_write(PORT_ADDR, 8'h40);
    repeat (15) tick();
    chk1("t4_in_read", rd_n, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk1("t4_cs_n", cs_n, 1'b1);
    chk1("t4_rd_n", rd_n, 1'b1);
    chk1("t4_ad_oe", ad_oe, 1'b0);
    chk1("t4_busy", busy, 1'b0);
    @(negedge clock) reset = 1'b1;
    tick();
    do_read(PORT_STATUS, 8'h00, "t4_status");
    do_read(PORT_DATA, 8'h00, "t4_data");

    // Non-BCD byte.
    ad_in = 8'h3A;
    do_write(PORT_ADDR, 8'h05);
    wait_idle("t5_idle");
`ifdef RTC_BCD_CHECK_EN
    do_read(PORT_STATUS, 8'h0A, "t5_status");
`else
    do_read(PORT_STATUS, 8'h02, "t5_status");
`endif
    do_read(PORT_DATA, 8'h3A, "t5_data");
    do_read(PORT_STATUS, 8'h00, "t5_status_clr");

    repeat (3) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_reader.md
Name: rtc_bus_reader

Overview:
- Read-side companion to the PicoBlaze write path that loads the clock/date/timer display registers.
- Performs one RTC register read per PicoBlaze request over a multiplexed address/data RTC bus (ALE, CS#, RD#, WR#), with timed phases.
- Presents the captured byte and a status byte back to PicoBlaze through a registered input-port mux (port_id / read_strobe / in_port).
- Sits between the PicoBlaze I/O ports and the RTC pads, alongside the existing write-side decoders.

Parameters:
- PORT_ADDR, 8'h10: write port; in_dato = RTC register address; starts a read.
- PORT_DATA, 8'h11: read port; last captured RTC byte.
- PORT_STATUS, 8'h12: read port; status byte.
- T_PHASE, 10: clock cycles per ADDR, READ and RECOVER phase (100 ns at 100 MHz); legal range 1..255.
- T_TURN, 2: bus turnaround cycles; legal range 1..255.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- in_dato  input  8  PicoBlaze out_port data
- port_id  input  8  PicoBlaze port address
- write_strobe  input  1  PicoBlaze output strobe
- read_strobe  input  1  PicoBlaze input strobe
- in_port  output  8  registered data to PicoBlaze
- ad_out  output  8  RTC A/D bus drive value
- ad_oe  output  1  tristate enable for ad_out at the pad
- ad_in  input  8  RTC A/D bus sampled value
- ale  output  1  address latch enable, active high
- cs_n  output  1  RTC chip select
- rd_n  output  1  RTC read strobe
- wr_n  output  1  RTC write strobe; always 1 in this block
- busy  output  1  transaction in progress

Behaviour:
- Reset (reset=0, asynchronous) forces all of the following:
  - state=IDLE; in_port=0; ad_out=0; ad_oe=0; ale=0; cs_n=1; rd_n=1; wr_n=1; busy=0.
  - data_reg=0; data_valid=0; overrun=0.
- Start condition: write_strobe=1 and port_id=PORT_ADDR while in IDLE.
  - Latch in_dato into addr_reg.
  - Next cycle enter ADDR with busy=1.
- FSM sequence. Each phase uses a down-counter loaded on entry; the state exits when the counter reaches 0.
  - ADDR, T_PHASE cycles: cs_n=0, ale=1, ad_oe=1, ad_out=addr_reg.
  - HOLD, 1 cycle: ale=0; ad_oe and ad_out unchanged.
  - TURN, T_TURN cycles: ad_oe=0; cs_n stays 0.
  - READ, T_PHASE cycles: rd_n=0. ad_in is captured into data_reg on the last READ cycle (rd_n still 0).
  - RECOVER, T_PHASE cycles: cs_n=1, rd_n=1. data_valid is set on entry.
  - Then IDLE with busy=0.
- Transaction length: 1 + T_PHASE + 1 + T_TURN + T_PHASE + T_PHASE cycles from the start strobe to busy=0. With defaults this is 34 cycles.
- A PORT_ADDR write while busy=1 is ignored (addr_reg is unchanged) and sets overrun. overrun is sticky.
- Writes to any other port_id have no effect.
- in_port is registered every cycle:
  - port_id=PORT_DATA → data_reg.
  - port_id=PORT_STATUS → {4'b0, bcd_err, overrun, data_valid, busy}.
  - Any other port_id → 8'h00.
- Read side effects, applied at the edge where read_strobe=1:
  - PORT_DATA clears data_valid.
  - PORT_STATUS clears overrun.
- Simultaneous events:
  - A data_valid set and a PORT_DATA read clear in the same cycle: set wins.
  - An overrun set and a PORT_STATUS read clear in the same cycle: set wins.
- ad_oe and rd_n are never both active; TURN guarantees at least T_TURN cycles between them.
- Asserting reset mid-transaction aborts the transaction immediately: the bus is released (cs_n=1, ad_oe=0) and data_reg=0.

Optional Feature:
- Macro RTC_BCD_CHECK_EN.
- Defined: at capture, if either nibble of ad_in is greater than 9, set bcd_err (status bit 3, sticky, cleared by a PORT_STATUS read). data_reg is still loaded.
- Not defined: bcd_err is tied to 0 and there is no checking logic.

Decomposition:
- Package rtc_bus_pkg holds:
  - the port ID constants PORT_ADDR, PORT_DATA, PORT_STATUS;
  - the state encodings IDLE, ADDR, HOLD, TURN, READ, RECOVER;
  - the status bit indices BUSY_B=0, VALID_B=1, OVR_B=2, BCD_B=3.
- One sub-module, rtc_phase_timer: an 8-bit loadable down-counter with load, load value and zero flag. It is shared by all timed states.

Test Plan:
- Read address 8'h21 with ad_in=8'h45. Required: ale high for exactly 10 cycles with ad_out=8'h21; rd_n low for 10 cycles; busy drops 34 cycles after the strobe. A subsequent PORT_STATUS read returns 8'h02, and a PORT_DATA read returns 8'h45.
- Issue a second PORT_ADDR write (in_dato=8'h22) at cycle 5 of a transaction. Required: the bus still shows addr 8'h21; the status read gives 8'h05; a second status read gives 8'h00 while idle with data already consumed.
- Drive a PORT_DATA read_strobe in the exact cycle data_valid is set. Required: data_valid remains 1.
- Assert reset during READ. Required: cs_n=1, rd_n=1, ad_oe=0 and busy=0 immediately, asynchronously and without a clock edge. After release, a status read gives 8'h00.
- Bus contention check: a monitor asserts that no cycle has ad_oe=1 and rd_n=0 together, and that at least 2 cycles separate ad_oe falling from rd_n falling.
- With RTC_BCD_CHECK_EN defined, ad_in=8'h3A. Required: PORT_DATA returns 8'h3A and the status read gives 8'h0A. Without the macro, the status read gives 8'h02.
